// File: rtl/vespa_int_pkg.sv
// Shared definitions for the VeSPA interrupt controller: register map,
// controller states and STATUS register field layout.
package vespa_int_pkg;

    localparam logic [2:0] REG_ENABLE  = 3'd0;
    localparam logic [2:0] REG_MODE    = 3'd1;
    localparam logic [2:0] REG_PRIO    = 3'd2;
    localparam logic [2:0] REG_PENDING = 3'd3;
    localparam logic [2:0] REG_STATUS  = 3'd4;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_REQ  = 1'b1
    } intState_t;

    // STATUS = {depth, active channel, current priority, stack error}
    localparam int unsigned STAT_ERR_LSB  = 0;
    localparam int unsigned STAT_PRIO_LSB = 1;

    function automatic int unsigned statChLsb(input int unsigned prioW);
        return STAT_PRIO_LSB + prioW;
    endfunction

    function automatic int unsigned statDepthLsb(input int unsigned prioW, input int unsigned chW);
        return STAT_PRIO_LSB + prioW + chW;
    endfunction

endpackage

// File: rtl/vespa_int_ctrl_arbiter.sv
// Combinational max-priority select over N_CH requests; ties resolve to the
// lowest channel index.
module int_priority_arbiter #(
    parameter int unsigned N_CH   = 4,
    parameter int unsigned PRIO_W = 2,
    localparam int unsigned CH_W  = $clog2(N_CH)
) (
    input  logic [N_CH-1:0]        req,
    input  logic [N_CH*PRIO_W-1:0] prio,
    output logic                   valid,
    output logic [CH_W-1:0]        idx,
    output logic [PRIO_W-1:0]      winPrio
);

    always_comb begin
        valid   = 1'b0;
        idx     = '0;
        winPrio = '0;
        // Ascending scan with strict compare keeps the lowest index on ties
        for (int unsigned i = 0; i < N_CH; i++) begin
            if (req[i] && (!valid || prio[i*PRIO_W +: PRIO_W] > winPrio)) begin
                valid   = 1'b1;
                idx     = CH_W'(i);
                winPrio = prio[i*PRIO_W +: PRIO_W];
            end
        end
    end

endmodule

// File: rtl/vespa_int_ctrl.sv
// VeSPA interrupt controller: synchronised inputs, per-channel enable/mode/
// priority, nested preemption stack and CPU request/ack handshake.
module vespa_int_ctrl
    import vespa_int_pkg::*;
#(
    parameter int unsigned       N_CH       = 4,
    parameter int unsigned       PRIO_W     = 2,
    parameter int unsigned       NEST_DEPTH = 4,
    parameter int unsigned       DATA_W     = 32,
    parameter logic [DATA_W-1:0] VEC_BASE   = DATA_W'(32'h0000_0100),
    parameter int unsigned       VEC_STRIDE = 4,
    localparam int unsigned      CH_W       = $clog2(N_CH)
) (
    input  logic              i_Clk,
    input  logic              i_Rst,
    input  logic [N_CH-1:0]   i_Irq,
    input  logic              i_CfgWe,
    input  logic              i_CfgRe,
    input  logic [2:0]        i_CfgAddr,
    input  logic [DATA_W-1:0] i_CfgWData,
    output logic [DATA_W-1:0] o_CfgRData,
    output logic              o_IntRequest,
    output logic [CH_W-1:0]   o_IntNumber,
    output logic              o_IntPending,
    output logic [DATA_W-1:0] o_IntAddress,
    input  logic              i_IntAckAttended,
    input  logic              i_IntAckComplete,
    output logic              o_StackErr
);

    localparam int unsigned DEP_W  = $clog2(NEST_DEPTH + 1);
    localparam int unsigned ST_CH  = statChLsb(PRIO_W);
    localparam int unsigned ST_DEP = statDepthLsb(PRIO_W, CH_W);

    logic [N_CH-1:0]        sync1, sync2, irqQ, irqPrev;
    logic [N_CH-1:0]        pending, enableR, modeR, clrMask, cand;
    logic [N_CH*PRIO_W-1:0] prioR;
    intState_t              state, stateNext;
    logic                   load, push, popValid, eligible, stackErr;
    logic                   winValid;
    logic [CH_W-1:0]        winCh, reqCh, topCh;
    logic [PRIO_W-1:0]      winPrio, reqPrio, topPrio;
    logic [CH_W-1:0]        stackCh   [NEST_DEPTH];
    logic [PRIO_W-1:0]      stackPrio [NEST_DEPTH];
    logic [DEP_W-1:0]       depth, depthPop;
    logic [DATA_W-1:0]      rdNext;
    logic                   unusedWData;

    assign unusedWData = ^i_CfgWData[DATA_W-1:N_CH*PRIO_W];

    // Two synchroniser flops, then one registered stage used for edge detect
    always_ff @(posedge i_Clk) begin
        if (i_Rst) begin
            sync1   <= '0;
            sync2   <= '0;
            irqQ    <= '0;
            irqPrev <= '0;
        end else begin
            sync1   <= i_Irq;
            sync2   <= sync1;
            irqQ    <= sync2;
            irqPrev <= irqQ;
        end
    end

    always_ff @(posedge i_Clk) begin
        if (i_Rst) begin
            enableR <= '0;
            modeR   <= '0;
            prioR   <= '0;
        end else if (i_CfgWe) begin
            case (i_CfgAddr)
                REG_ENABLE: enableR <= i_CfgWData[N_CH-1:0];
                REG_MODE:   modeR   <= i_CfgWData[N_CH-1:0];
                REG_PRIO:   prioR   <= i_CfgWData[N_CH*PRIO_W-1:0];
                default:    ;
            endcase
        end
    end

    always_comb begin
        clrMask = '0;
        if (i_CfgWe && i_CfgAddr == REG_PENDING)
            clrMask = i_CfgWData[N_CH-1:0];
        if (push)
            clrMask[reqCh] = 1'b1;
        clrMask = clrMask & modeR;
    end

    // Edge channels: a fresh rise overrides any clear in the same cycle
    always_ff @(posedge i_Clk) begin
        if (i_Rst)
            pending <= '0;
        else
            pending <= (modeR & ((irqQ & ~irqPrev) | (pending & ~clrMask))) | (~modeR & irqQ);
    end

    assign cand = pending & enableR;

    int_priority_arbiter #(
        .N_CH   (N_CH),
        .PRIO_W (PRIO_W)
    ) u_arb (
        .req     (cand),
        .prio    (prioR),
        .valid   (winValid),
        .idx     (winCh),
        .winPrio (winPrio)
    );

    always_comb begin
        topCh   = '0;
        topPrio = '0;
        for (int unsigned i = 0; i < NEST_DEPTH; i++) begin
            if (depth == DEP_W'(i + 1)) begin
                topCh   = stackCh[i];
                topPrio = stackPrio[i];
            end
        end
    end

    assign eligible = winValid && (depth == '0 ||
                      (winPrio > topPrio && depth < DEP_W'(NEST_DEPTH)));
    assign push     = (state == ST_REQ) && i_IntAckAttended;
    assign popValid = i_IntAckComplete && depth != '0;
    assign depthPop = popValid ? depth - 1'b1 : depth;

    always_comb begin
        stateNext = state;
        load      = 1'b0;
        case (state)
            ST_IDLE: if (eligible) begin
                stateNext = ST_REQ;
                load      = 1'b1;
            end
            ST_REQ:  if (i_IntAckAttended) stateNext = ST_IDLE;
            default: stateNext = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_Clk) begin
        if (i_Rst) state <= ST_IDLE;
        else       state <= stateNext;
    end

    always_ff @(posedge i_Clk) begin
        if (i_Rst) begin
            reqCh        <= '0;
            reqPrio      <= '0;
            o_IntAddress <= '0;
        end else if (load) begin
            reqCh        <= winCh;
            reqPrio      <= winPrio;
            o_IntAddress <= VEC_BASE + DATA_W'(winCh) * DATA_W'(VEC_STRIDE);
        end
    end

    // Pop is applied before push so a same-cycle complete+attend replaces the top
    always_ff @(posedge i_Clk) begin
        if (i_Rst) begin
            depth    <= '0;
            stackErr <= 1'b0;
            for (int unsigned i = 0; i < NEST_DEPTH; i++) begin
                stackCh[i]   <= '0;
                stackPrio[i] <= '0;
            end
        end else begin
            if (push && depthPop < DEP_W'(NEST_DEPTH)) begin
                for (int unsigned i = 0; i < NEST_DEPTH; i++) begin
                    if (depthPop == DEP_W'(i)) begin
                        stackCh[i]   <= reqCh;
                        stackPrio[i] <= reqPrio;
                    end
                end
                depth <= depthPop + 1'b1;
            end else begin
                depth <= depthPop;
            end
            if (i_IntAckComplete && depth == '0)
                stackErr <= 1'b1;
            else if (i_CfgWe && i_CfgAddr == REG_STATUS)
                stackErr <= 1'b0;
        end
    end

    always_comb begin
        rdNext = '0;
        case (i_CfgAddr)
            REG_ENABLE:  rdNext[N_CH-1:0]        = enableR;
            REG_MODE:    rdNext[N_CH-1:0]        = modeR;
            REG_PRIO:    rdNext[N_CH*PRIO_W-1:0] = prioR;
            REG_PENDING: rdNext[N_CH-1:0]        = pending;
            REG_STATUS: begin
                rdNext[STAT_ERR_LSB]            = stackErr;
                rdNext[STAT_PRIO_LSB +: PRIO_W] = topPrio;
                rdNext[ST_CH +: CH_W]           = topCh;
                rdNext[ST_DEP +: DEP_W]         = depth;
            end
            default: ;
        endcase
    end

    always_ff @(posedge i_Clk) begin
        if (i_Rst)        o_CfgRData <= '0;
        else if (i_CfgRe) o_CfgRData <= rdNext;
    end

    assign o_IntRequest = (state == ST_REQ);
    assign o_IntPending = (state == ST_REQ);
    assign o_IntNumber  = reqCh;
    assign o_StackErr   = stackErr;

endmodule

// File: doc/vespa_int_ctrl.md
# vespa_int_ctrl

Parametrised interrupt controller for the VeSPA SoC. It is the successor to the fixed 2-bit interrupt-number scheme. It collects N_CH external interrupt lines and applies per-channel enable, edge/level mode and priority. It supports nested preemption up to NEST_DEPTH levels and drives the CPU's request/pending/ack handshake together with the vector address. It sits on the SoC bus beside the CPU and is configured through a small register port.

## Interface
Parameters:
- N_CH, 4, number of interrupt channels (2..16)
- PRIO_W, 2, priority field width per channel; higher value means more urgent
- NEST_DEPTH, 4, maximum number of nested active interrupts
- DATA_W, 32, bus and vector width
- VEC_BASE, 32'h0000_0100, vector address of channel 0
- VEC_STRIDE, 4, byte distance between channel vectors

Ports:
- i_Clk  in  1  clock
- i_Rst  in  1  synchronous, active-high reset
- i_Irq  in  N_CH  raw interrupt lines, asynchronous
- i_CfgWe  in  1  config write strobe
- i_CfgRe  in  1  config read strobe
- i_CfgAddr  in  3  register index
- i_CfgWData  in  DATA_W  write data
- o_CfgRData  out  DATA_W  read data, registered
- o_IntRequest  out  1  request to the CPU
- o_IntNumber  out  $clog2(N_CH)  channel being requested
- o_IntPending  out  1  request raised and not yet attended
- o_IntAddress  out  DATA_W  vector of o_IntNumber
- i_IntAckAttended  in  1  one-cycle pulse: CPU entered the ISR
- i_IntAckComplete  in  1  one-cycle pulse: CPU executed RETI
- o_StackErr  out  1  sticky flag: ack-complete received with no active interrupt

## Operation
- Registers:
  - 0 ENABLE: N_CH bits.
  - 1 MODE: 1 = edge, 0 = level.
  - 2 PRIO: packed, channel i occupies bits [i*PRIO_W +: PRIO_W].
  - 3 PENDING: read; write-1-to-clear, edge channels only.
  - 4 STATUS: {depth, active channel, current priority, o_StackErr}; a write clears o_StackErr.
  - Other addresses read 0 and ignore writes.
- Input path: 2-flop synchroniser per channel.
  - Edge mode: pending bit set on a synchronised 0→1 transition.
  - Level mode: pending bit follows the synchronised level.
- Candidate set: pending & ENABLE.
  - Winner = highest PRIO; ties go to the lowest index.
  - The winner is eligible only if depth==0, or its priority is strictly greater than the stack-top priority and depth<NEST_DEPTH.
- FSM:
  - IDLE → REQ when an eligible winner exists. The channel is latched into o_IntNumber/o_IntAddress, and o_IntRequest=o_IntPending=1.
  - REQ → IDLE on i_IntAckAttended. On that edge:
    - Push {channel, priority}; depth+1.
    - Clear the edge-mode pending bit of that channel.
    - Drop o_IntRequest/o_IntPending.
  - While in REQ the latched channel is held. A higher-priority arrival does not retarget it.
- i_IntAckComplete pops the stack (depth-1) in any state. If depth==0 it sets o_StackErr and leaves the stack unchanged.
- Vector arithmetic: o_IntAddress = VEC_BASE + chan*VEC_STRIDE, modulo 2^DATA_W.

## Timing
- Reset values:
  - All outputs 0.
  - ENABLE, MODE, PRIO, pending, stack and depth all 0.
  - FSM in IDLE.
- Latency: i_Irq first sampled high at edge k → pending visible after edge k+3 → o_IntRequest high after edge k+4.
- Handshake:
  - o_IntRequest is held until i_IntAckAttended.
  - An ack pulse while in IDLE is ignored.
- Config writes take effect on the following edge.
  - Disabling the latched channel while in REQ does not withdraw the request.
  - o_CfgRData is valid one cycle after i_CfgRe and holds its value otherwise.
- Simultaneous events:
  - A new edge coinciding with a W1C clear or an attend-clear of the same bit: set wins.
  - AckComplete and AckAttended in the same cycle: pop then push, so depth is unchanged and the top entry is replaced.
- i_Rst mid-request or mid-nest: everything returns to reset values on the next edge.

## Structure
- Package vespa_int_pkg holds:
  - Register index constants.
  - FSM state encoding (IDLE, REQ).
  - STATUS field offsets.
- Sub-module int_priority_arbiter: combinational N_CH-input max-priority select with lowest-index tie-break; outputs valid, index and priority.
- Stack: NEST_DEPTH entries of {channel, priority} held in flops.

## Test plan
- PRIO ch2=3, ENABLE=4'b0100, MODE=edge, pulse i_Irq[2] for 1 cycle → o_IntRequest rises 4 cycles later; o_IntNumber=2; o_IntAddress=0x108; attend pulse → request drops; PENDING bit 2=0; STATUS depth=1.
- Ch1 (prio 1) and ch3 (prio 1) raised together → ch1 served first; after attend+complete → ch3 requested.
- Nesting: ch0 prio1 active, ch2 prio3 raised → new request for ch2, depth becomes 2. A further ch1 prio1 is not requested until two completes have occurred.
- NEST_DEPTH=2 with two active entries; raise a prio-3 channel → no request until one complete.
- i_IntAckComplete with depth 0 → o_StackErr=1; write STATUS → o_StackErr=0.
- Level channel held high across attend/complete → re-requested; assert i_Rst while in REQ → all outputs 0 on the next edge.
